// File: rtl/pls_onchip_mem_master.sv
// pls_onchip_mem_master: Avalon-MM block initiator for the PLS on-chip scratch RAM.
// Moves N-word blocks between valid/ready streams and the single-port RAM slave.
module pls_onchip_mem_master #(
    parameter int ADDR_W       = 2,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [ADDR_W:0]       cmd_len,
    input  logic [DATA_W/8-1:0]   cmd_byteenable,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  done,
    output logic [ADDR_W-1:0]     avm_address,
    output logic [DATA_W/8-1:0]   avm_byteenable,
    output logic                  avm_chipselect,
    output logic                  avm_write,
    output logic [DATA_W-1:0]     avm_writedata,
    output logic                  avm_clken,
    input  logic [DATA_W-1:0]     avm_readdata
);
    localparam int BE_W  = DATA_W / 8;
    localparam int LAT_W = 2;
    localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ISSUE,
        RD_WAIT,
        RD_HOLD,
        DONE
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_curAddr;
    logic [ADDR_W:0]     r_remain;
    logic [BE_W-1:0]     r_be;
    logic [LAT_W-1:0]    r_latCnt;
    logic [DATA_W-1:0]   r_rdData;
    logic                r_rdValid;
    logic                r_done;

    logic                w_wrFire;
    logic                w_rdIssue;

    assign w_wrFire  = (r_state == WRITE) && wr_valid;
    assign w_rdIssue = (r_state == RD_ISSUE);

    // done is raised on the transition into DONE so it is high exactly while in DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_curAddr <= '0;
            r_remain  <= '0;
            r_be      <= '0;
            r_latCnt  <= '0;
            r_rdData  <= '0;
            r_rdValid <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_curAddr <= cmd_addr;
                        r_remain  <= cmd_len;
                        r_be      <= cmd_byteenable;
                        if (cmd_len == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else if (cmd_write) begin
                            r_state <= WRITE;
                        end else begin
                            r_state <= RD_ISSUE;
                        end
                    end
                end
                WRITE: begin
                    if (wr_valid) begin
                        r_curAddr <= r_curAddr + ADDR_W'(1);
                        r_remain  <= r_remain - LAST_WORD;
                        if (r_remain == LAST_WORD) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                RD_ISSUE: begin
                    r_latCnt <= LAT_W'(READ_LATENCY);
                    r_state  <= RD_WAIT;
                end
                RD_WAIT: begin
                    r_latCnt <= r_latCnt - LAT_W'(1);
                    if (r_latCnt == LAT_W'(1)) begin
                        r_rdData  <= avm_readdata;
                        r_rdValid <= 1'b1;
                        r_state   <= RD_HOLD;
                    end
                end
                RD_HOLD: begin
                    if (rd_ready) begin
                        r_rdValid <= 1'b0;
                        r_curAddr <= r_curAddr + ADDR_W'(1);
                        r_remain  <= r_remain - LAST_WORD;
                        if (r_remain == LAST_WORD) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RD_ISSUE;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Write-side bus signals follow the stream combinationally so the slave captures on the handshake edge
    assign cmd_ready      = (r_state == IDLE) && !reset;
    assign wr_ready       = (r_state == WRITE) && !reset;
    assign avm_chipselect = !reset && (w_wrFire || w_rdIssue);
    assign avm_write      = !reset && w_wrFire;
    assign avm_address    = reset ? '0 : r_curAddr;
    assign avm_writedata  = (!reset && (r_state == WRITE)) ? wr_data : '0;
    assign avm_byteenable = reset ? '0 : ((r_state == WRITE) ? r_be : '1);
    assign avm_clken      = !reset;

    assign rd_data  = r_rdData;
    assign rd_valid = r_rdValid;
    assign done     = r_done;

endmodule

// File: tb/tb_pls_onchip_mem_master.sv
// tb_pls_onchip_mem_master: directed plus randomized block commands against a behavioural RAM model.
// Expected bus addresses, read data and done pulses come from a word-array reference of the scratch memory.
module tb_pls_onchip_mem_master;
    localparam int ADDR_W       = 2;
    localparam int DATA_W       = 32;
    localparam int READ_LATENCY = 1;
    localparam int BE_W         = DATA_W / 8;
    localparam int DEPTH        = 1 << ADDR_W;

    logic                clk = 1'b0;
    logic                reset;
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_write;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [ADDR_W:0]     cmd_len;
    logic [BE_W-1:0]     cmd_byteenable;
    logic [DATA_W-1:0]   wr_data;
    logic                wr_valid;
    logic                wr_ready;
    logic [DATA_W-1:0]   rd_data;
    logic                rd_valid;
    logic                rd_ready;
    logic                done;
    logic [ADDR_W-1:0]   avm_address;
    logic [BE_W-1:0]     avm_byteenable;
    logic                avm_chipselect;
    logic                avm_write;
    logic [DATA_W-1:0]   avm_writedata;
    logic                avm_clken;
    logic [DATA_W-1:0]   avm_readdata;

    logic [DATA_W-1:0]   ramMem [DEPTH];
    logic [DATA_W-1:0]   ramRd;
    logic [DATA_W-1:0]   refMem [DEPTH];
    logic [DATA_W-1:0]   wrQueue [$];

    int checkCount = 0;
    int errorCount = 0;
    int doneCount  = 0;
    int expDone    = 0;

    always #5 clk = ~clk;

    pls_onchip_mem_master #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .READ_LATENCY(READ_LATENCY)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_len(cmd_len),
        .cmd_byteenable(cmd_byteenable),
        .wr_data(wr_data),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .rd_ready(rd_ready),
        .done(done),
        .avm_address(avm_address),
        .avm_byteenable(avm_byteenable),
        .avm_chipselect(avm_chipselect),
        .avm_write(avm_write),
        .avm_writedata(avm_writedata),
        .avm_clken(avm_clken),
        .avm_readdata(avm_readdata)
    );

    // On-chip RAM slave: byte-masked writes, registered read address, one cycle read latency
    always @(posedge clk) begin
        if (avm_clken && avm_chipselect) begin
            if (avm_write) begin
                for (int b = 0; b < BE_W; b++)
                    if (avm_byteenable[b]) ramMem[avm_address][8*b +: 8] <= avm_writedata[8*b +: 8];
            end else begin
                ramRd <= ramMem[avm_address];
            end
        end
    end
    assign avm_readdata = ramRd;

    always @(negedge clk) if (done === 1'b1) doneCount++;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one block command; gapMode 0 = streams always ready, 1 = random gaps, 2 = first read word held 5 cycles
    task automatic applyStimulus(input bit isWrite, input int addr, input int len, input logic [BE_W-1:0] be,
                                 input int gapMode, input int abortAfter);
        int sent, got, cyc, issued, holdCnt, lastAcc, a;
        bit aborted;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = isWrite;
        cmd_addr = addr[ADDR_W-1:0];
        cmd_len = len[ADDR_W:0];
        cmd_byteenable = be;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        #1 checkOutput("cmd_ready_idle", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        sent = 0; got = 0; cyc = 0; issued = 0; holdCnt = 0; lastAcc = -1; aborted = 1'b0;
        if (len == 0) begin
            #1;
            checkOutput("len0_done", done, 1);
            checkOutput("len0_no_cs", avm_chipselect, 0);
            checkOutput("cmd_ready_in_done", cmd_ready, 0);
        end else if (isWrite) begin
            while (sent < len && cyc < 200 && !aborted) begin
                if (cyc > 0) @(negedge clk);
                wr_valid = (gapMode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
                wr_data = (wrQueue.size() > 0) ? wrQueue[0] : $urandom;
                cmd_valid = (cyc == 1);
                rd_ready = $urandom_range(0, 1);
                #1;
                checkOutput("wr_ready", wr_ready, 1);
                checkOutput("cmd_ready_busy", cmd_ready, 0);
                checkOutput("avm_write", avm_write, wr_valid);
                checkOutput("avm_cs_wr", avm_chipselect, wr_valid);
                if (wr_valid) begin
                    a = (addr + sent) % DEPTH;
                    checkOutput("wr_addr", avm_address, a);
                    checkOutput("wr_data", avm_writedata, wr_data);
                    checkOutput("wr_be", avm_byteenable, be);
                    for (int b = 0; b < BE_W; b++)
                        if (be[b]) refMem[a][8*b +: 8] = wr_data[8*b +: 8];
                    if (wrQueue.size() > 0) void'(wrQueue.pop_front());
                    sent++;
                    if (sent == abortAfter) aborted = 1'b1;
                end
                cyc++;
            end
            cmd_valid = 1'b0;
            if (aborted) begin
                @(negedge clk);
                reset = 1'b1;
                wr_valid = 1'b1;
                #1;
                checkOutput("abort_ctl", {cmd_ready, wr_ready, rd_valid, done, avm_chipselect, avm_write,
                                          avm_clken, avm_address, avm_byteenable}, 0);
                checkOutput("abort_data", {rd_data, avm_writedata}, 0);
                repeat (2) @(negedge clk);
                reset = 1'b0;
                wr_valid = 1'b0;
                wrQueue.delete();
                @(negedge clk);
                #1;
                checkOutput("abort_no_done", done, 0);
                checkOutput("abort_idle", cmd_ready, 1);
                return;
            end
            checkOutput("wr_count", sent, len);
            @(negedge clk);
            wr_valid = 1'b0;
            #1;
            checkOutput("wr_done", done, 1);
            checkOutput("wr_done_no_cs", avm_chipselect, 0);
        end else begin
            while (got < len && cyc < 400) begin
                if (cyc > 0) @(negedge clk);
                wr_valid = $urandom_range(0, 1);
                if (gapMode == 0) rd_ready = 1'b1;
                else if (gapMode == 1) rd_ready = $urandom_range(0, 1);
                else rd_ready = (holdCnt >= 5);
                #1;
                checkOutput("wr_ready_rd", wr_ready, 0);
                checkOutput("avm_write_rd", avm_write, 0);
                if (avm_chipselect) begin
                    issued++;
                    checkOutput("rd_issue_addr", avm_address, (addr + got) % DEPTH);
                    checkOutput("rd_issue_be", avm_byteenable, {BE_W{1'b1}});
                end
                if (rd_valid) begin
                    checkOutput("cs_in_hold", avm_chipselect, 0);
                    checkOutput("rd_data", rd_data, refMem[(addr + got) % DEPTH]);
                    if (gapMode == 0 && got == 0 && lastAcc < 0)
                        checkOutput("rd_first_lat", cyc, READ_LATENCY + 1);
                    if (rd_ready) begin
                        if (gapMode == 0 && lastAcc >= 0)
                            checkOutput("rd_spacing", cyc - lastAcc, READ_LATENCY + 2);
                        lastAcc = cyc;
                        got++;
                    end else begin
                        holdCnt++;
                    end
                end
                cyc++;
            end
            checkOutput("rd_count", got, len);
            checkOutput("rd_issue_count", issued, len);
            @(negedge clk);
            rd_ready = 1'b0;
            wr_valid = 1'b0;
            #1;
            checkOutput("rd_done", done, 1);
            checkOutput("rd_valid_low", rd_valid, 0);
        end
        expDone++;
        @(negedge clk);
        #1;
        checkOutput("done_one_cycle", done, 0);
        checkOutput("back_to_idle", cmd_ready, 1);
    endtask

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr = '0;
        cmd_len = '0;
        cmd_byteenable = '0;
        wr_data = '0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        ramRd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ramMem[i] = '0;
            refMem[i] = '0;
        end
        repeat (3) @(negedge clk);
        wr_valid = 1'b1;
        #1;
        checkOutput("reset_ctl", {cmd_ready, wr_ready, rd_valid, done, avm_chipselect, avm_write,
                                  avm_clken, avm_address, avm_byteenable}, 0);
        checkOutput("reset_data", {rd_data, avm_writedata}, 0);
        @(negedge clk);
        reset = 1'b0;
        wr_valid = 1'b0;
        #1;
        checkOutput("post_reset_ready", cmd_ready, 1);
        checkOutput("post_reset_clken", avm_clken, 1);

        wrQueue = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        applyStimulus(1'b1, 0, 4, 4'hF, 0, -1);
        applyStimulus(1'b0, 0, 4, 4'hF, 0, -1);
        checkOutput("model_seed_w3", refMem[3], 32'h44444444);

        wrQueue = '{32'h0000AAAA, 32'h0000BBBB};
        applyStimulus(1'b1, 3, 2, 4'b0011, 0, -1);
        applyStimulus(1'b0, 3, 2, 4'hF, 0, -1);

        applyStimulus(1'b0, 1, 1, 4'hF, 2, -1);
        applyStimulus(1'b1, 2, 0, 4'hF, 0, -1);

        wrQueue = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
        applyStimulus(1'b1, 0, 4, 4'hF, 0, 2);
        applyStimulus(1'b0, 0, 4, 4'hF, 0, -1);

        for (int n = 0; n < 30; n++)
            applyStimulus($urandom_range(0, 1), $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH),
                          BE_W'($urandom), $urandom_range(0, 1), -1);

        for (int i = 0; i < DEPTH; i++)
            checkOutput("ram_final", ramMem[i], refMem[i]);
        checkOutput("done_pulses", doneCount, expDone);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
